// File: rtl/countdown_pkg.sv
// Shared constants for the countdown controller: state codes, state width, default count width.
package countdown_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DEF_W   = 8;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_RUN     = 3'd2;
  localparam state_t ST_PAUSED  = 3'd3;
  localparam state_t ST_EXPIRED = 3'd4;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Button, datapath and status signals between the countdown controller and its surroundings.
interface countdown_ctrl_if
  import countdown_pkg::*;
#(
  parameter int unsigned W = DEF_W
);
  logic               start_btn;
  logic               pause_btn;
  logic               clear_btn;
  logic [W-1:0]       preset;
  logic [W-1:0]       count;
  logic               tick_o;
  logic               load_o;
  logic               enable_o;
  logic               alarm_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    output start_btn, pause_btn, clear_btn, preset, count,
    input  tick_o, load_o, enable_o, alarm_o, state_o
  );

  modport slave (
    input  start_btn, pause_btn, clear_btn, preset, count,
    output tick_o, load_o, enable_o, alarm_o, state_o
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-clk tick each time the counter wraps from TICK_DIV-1 to 0.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == LAST);
    end
  end

  assign tick = r_tick;
endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer controller: button conditioning, run/pause/expire FSM and alarm hold timer.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned ALARM_TICKS = 10,
  parameter int unsigned W           = DEF_W
) (
  input logic             clk,
  input logic             rst_n,
  countdown_ctrl_if.slave bus
);
  localparam int unsigned   AW         = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  logic          w_tick;
  logic [2:0]    w_btn;
  logic [2:0]    r_sync1, r_sync2, r_prev, r_armed, r_pulse;
  logic [1:0]    r_vld;
  state_t        r_state, w_next;
  logic [AW-1:0] r_alarm_cnt, w_alarm_next;
  logic          r_load, r_enable, r_alarm;
  logic          w_start, w_pause, w_clear;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  assign w_btn = {bus.clear_btn, bus.pause_btn, bus.start_btn};

  // A button only arms once a genuine low has come through the synchronizer,
  // so a press held across reset release never yields a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_armed <= '0;
      r_pulse <= '0;
      r_vld   <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | ({3{r_vld[1]}} & ~r_sync2);
      r_pulse <= r_sync2 & ~r_prev & r_armed;
    end
  end

  assign w_start = r_pulse[0];
  assign w_pause = r_pulse[1];
  assign w_clear = r_pulse[2];

  always_comb begin
    w_next       = r_state;
    w_alarm_next = '0;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_LOAD;
      ST_LOAD:   if (w_tick)  w_next = ST_RUN;
      ST_RUN: begin
        if (w_start)               w_next = ST_LOAD;
        else if (w_pause)          w_next = ST_PAUSED;
        else if (bus.count == '0)  w_next = ST_EXPIRED;
      end
      ST_PAUSED: begin
        if (w_start)      w_next = ST_LOAD;
        else if (w_pause) w_next = ST_RUN;
      end
      ST_EXPIRED: begin
        if (w_start) begin
          w_next = ST_LOAD;
        end else begin
          w_alarm_next = r_alarm_cnt;
          if (w_tick) begin
            if (r_alarm_cnt == ALARM_LAST) begin
              w_next       = ST_IDLE;
              w_alarm_next = '0;
            end else begin
              w_alarm_next = r_alarm_cnt + 1'b1;
            end
          end
        end
      end
      default:   w_next = ST_IDLE;
    endcase
    if (w_clear) begin
      w_next       = ST_IDLE;
      w_alarm_next = '0;
    end
  end

  // Outputs are decoded from the next state so they register alongside r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alarm_cnt <= '0;
      r_load      <= 1'b0;
      r_enable    <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_alarm_cnt <= w_alarm_next;
      r_load      <= (w_next == ST_LOAD);
      r_enable    <= (w_next == ST_RUN);
      r_alarm     <= (w_next == ST_EXPIRED);
    end
  end

  assign bus.tick_o   = w_tick;
  assign bus.load_o   = r_load;
  assign bus.enable_o = r_enable;
  assign bus.alarm_o  = r_alarm;
  assign bus.state_o  = r_state;
endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a behavioural down-counter datapath (TICK_DIV=4, ALARM_TICKS=3).
module tb_countdown_ctrl;
  import countdown_pkg::*;

  localparam int NV = 20;

  typedef struct {
    logic [2:0] btn;   // {clear, pause, start}
    int         pre;
    logic [2:0] st;
    logic       ld;
    logic       en;
    logic       al;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_b = 1'b0, pause_b = 1'b0, clear_b = 1'b0;
  logic [7:0] preset_r = 8'd0;
  logic [7:0] dp_count;

  int n_pass = 0, n_total = 0;
  int overlap_cnt = 0, load_cyc = 0, load_rise = 0;
  logic prev_load = 1'b0;
  int cyc, n, na, snap;
  vec_t tbl [NV];

  countdown_ctrl_if #(.W(8)) bus ();

  countdown_ctrl #(.TICK_DIV(4), .ALARM_TICKS(3), .W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.start_btn = start_b;
  assign bus.pause_btn = pause_b;
  assign bus.clear_btn = clear_b;
  assign bus.preset    = preset_r;
  assign bus.count     = dp_count;

  always #5 clk = ~clk;

  // Down-counter datapath: loads or decrements only on ticks, saturating at zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_count <= 8'd0;
    else if (bus.tick_o) begin
      if (bus.load_o)                          dp_count <= preset_r;
      else if (bus.enable_o && dp_count != 0)  dp_count <= dp_count - 8'd1;
    end
  end

  always @(negedge clk) begin
    if (bus.load_o && bus.enable_o) overlap_cnt++;
    if (bus.load_o) load_cyc++;
    if (bus.load_o && !prev_load) load_rise++;
    prev_load = bus.load_o;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Called at a negedge; returns at the negedge just after the FSM has acted on the pulse.
  task automatic press(input logic [2:0] b);
    start_b = b[0]; pause_b = b[1]; clear_b = b[2];
    repeat (2) @(negedge clk);
    start_b = 1'b0; pause_b = 1'b0; clear_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outs(input string nm, input logic [2:0] st, input logic ld,
                            input logic en, input logic al);
    check({nm, "_state"},  32'(bus.state_o),  32'(st));
    check({nm, "_load"},   32'(bus.load_o),   32'(ld));
    check({nm, "_enable"}, 32'(bus.enable_o), 32'(en));
    check({nm, "_alarm"},  32'(bus.alarm_o),  32'(al));
  endtask

  initial begin
    tbl[0]  = '{3'b010, 0, ST_IDLE,    1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'b100, 0, ST_IDLE,    1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'b001, 0, ST_LOAD,    1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3'b000, 8, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[4]  = '{3'b010, 0, ST_PAUSED,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'b010, 0, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[6]  = '{3'b001, 0, ST_LOAD,    1'b1, 1'b0, 1'b0};
    tbl[7]  = '{3'b000, 8, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[8]  = '{3'b011, 0, ST_LOAD,    1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 8, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[10] = '{3'b110, 0, ST_IDLE,    1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'b001, 0, ST_LOAD,    1'b1, 1'b0, 1'b0};
    tbl[12] = '{3'b000, 8, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[13] = '{3'b010, 0, ST_PAUSED,  1'b0, 1'b0, 1'b0};
    tbl[14] = '{3'b001, 0, ST_LOAD,    1'b1, 1'b0, 1'b0};
    tbl[15] = '{3'b000, 8, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[16] = '{3'b010, 0, ST_PAUSED,  1'b0, 1'b0, 1'b0};
    tbl[17] = '{3'b010, 0, ST_RUN,     1'b0, 1'b1, 1'b0};
    tbl[18] = '{3'b101, 0, ST_IDLE,    1'b0, 1'b0, 1'b0};
    tbl[19] = '{3'b010, 0, ST_IDLE,    1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tick", 32'(bus.tick_o), 32'd0);
    check_outs("rst", ST_IDLE, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven transitions, long preset so the count never expires
    preset_r = 8'd200;
    for (int i = 0; i < NV; i++) begin
      repeat (tbl[i].pre) @(negedge clk);
      press(tbl[i].btn);
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].ld, tbl[i].en, tbl[i].al);
    end

    // Full countdown from 5 with alarm hold
    preset_r = 8'd5;
    press(3'b001);
    check("A_load", 32'(bus.load_o), 32'd1);
    cyc = 0; n = 0;
    while (!bus.enable_o && cyc < 20) begin
      if (bus.load_o && bus.tick_o) n++;
      @(negedge clk); cyc++;
    end
    check("A_enable_seen", 32'(bus.enable_o), 32'd1);
    check("A_load_left_on_tick", 32'(n), 32'd1);
    check("A_load_off", 32'(bus.load_o), 32'd0);
    check("A_count_start", 32'(dp_count), 32'd5);
    cyc = 0; n = 0;
    while (bus.state_o != ST_EXPIRED && cyc < 100) begin
      if (bus.enable_o && bus.tick_o) n++;
      @(negedge clk); cyc++;
    end
    check("A_run_ticks", 32'(n), 32'd5);
    check("A_count_zero", 32'(dp_count), 32'd0);
    cyc = 0; na = 0;
    while (bus.alarm_o && cyc < 100) begin
      if (bus.tick_o) na++;
      @(negedge clk); cyc++;
    end
    check("A_alarm_ticks", 32'(na), 32'd3);
    check("A_alarm_len", 32'(cyc >= 9 && cyc <= 12), 32'd1);
    check("A_idle", 32'(bus.state_o), 32'(ST_IDLE));

    // Pause at 3, hold, resume
    press(3'b001);
    cyc = 0;
    while (!(dp_count == 8'd4 && bus.tick_o && bus.enable_o) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("B_reach4", 32'(cyc < 200), 32'd1);
    press(3'b010);
    check("B_paused", 32'(bus.state_o), 32'(ST_PAUSED));
    check("B_enable_off", 32'(bus.enable_o), 32'd0);
    check("B_count3", 32'(dp_count), 32'd3);
    repeat (20) @(negedge clk);
    check("B_count_hold", 32'(dp_count), 32'd3);
    press(3'b010);
    check("B_resumed", 32'(bus.state_o), 32'(ST_RUN));
    cyc = 0; n = 0;
    while (bus.state_o != ST_EXPIRED && cyc < 100) begin
      if (bus.enable_o && bus.tick_o) n++;
      @(negedge clk); cyc++;
    end
    check("B_resume_ticks", 32'(n), 32'd3);
    press(3'b100);
    check("B_clear", 32'(bus.state_o), 32'(ST_IDLE));

    // start + clear together in RUN
    preset_r = 8'd200;
    press(3'b001);
    repeat (8) @(negedge clk);
    check("C_run", 32'(bus.state_o), 32'(ST_RUN));
    snap = load_cyc;
    press(3'b101);
    repeat (2) @(negedge clk);
    check("C_idle", 32'(bus.state_o), 32'(ST_IDLE));
    check("C_no_load", 32'(load_cyc - snap), 32'd0);

    // preset 0
    preset_r = 8'd0;
    press(3'b001);
    cyc = 0;
    while (bus.state_o != ST_RUN && cyc < 20) begin @(negedge clk); cyc++; end
    check("D_run_seen", 32'(bus.state_o), 32'(ST_RUN));
    @(negedge clk);
    check("D_expired", 32'(bus.state_o), 32'(ST_EXPIRED));
    check("D_alarm", 32'(bus.alarm_o), 32'd1);
    check("D_count0", 32'(dp_count), 32'd0);
    press(3'b100);

    // Reset mid-run with start held through release
    preset_r = 8'd5;
    press(3'b001);
    cyc = 0;
    while (!(dp_count == 8'd2 && bus.state_o == ST_RUN) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("E_reach2", 32'(cyc < 200), 32'd1);
    #2;
    rst_n = 1'b0;
    start_b = 1'b1;
    #1;
    check("E_rst_tick", 32'(bus.tick_o), 32'd0);
    check_outs("E_rst", ST_IDLE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = load_rise;
    repeat (10) @(negedge clk);
    start_b = 1'b0;
    repeat (4) @(negedge clk);
    check("E_held_no_pulse", 32'(load_rise - snap), 32'd0);
    check("E_idle", 32'(bus.state_o), 32'(ST_IDLE));
    press(3'b001);
    check("E_repress", 32'(bus.state_o), 32'(ST_LOAD));
    press(3'b100);

    // Long hold gives one LOAD entry; restart from EXPIRED
    preset_r = 8'd200;
    snap = load_rise;
    start_b = 1'b1;
    repeat (50) @(negedge clk);
    start_b = 1'b0;
    repeat (4) @(negedge clk);
    check("F_one_load", 32'(load_rise - snap), 32'd1);
    check("F_run", 32'(bus.state_o), 32'(ST_RUN));
    press(3'b100);
    preset_r = 8'd1;
    press(3'b001);
    cyc = 0;
    while (!bus.alarm_o && cyc < 100) begin @(negedge clk); cyc++; end
    check("F_alarm_seen", 32'(bus.alarm_o), 32'd1);
    start_b = 1'b1;
    repeat (2) @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    check("F_alarm_before", 32'(bus.alarm_o), 32'd1);
    @(negedge clk);
    check("F_restart_load", 32'(bus.state_o), 32'(ST_LOAD));
    check("F_alarm_dropped", 32'(bus.alarm_o), 32'd0);
    press(3'b100);

    check("no_load_enable_overlap", 32'(overlap_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
